// File: rtl/uart_tx_serializer_if.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer_if
// Bundles the serializer's load handshake and its transmit-side outputs.
//   load            : one-cycle request to send data_in
//   data_in         : byte to transmit, sampled on the accepted load edge
//   tx_out          : serial line, idle high
//   busy            : frame in progress
//   transmit_enable : high for every cycle of the data-bit phase
//   bit_count       : index of the data bit on tx_out, 0 outside data phase
//   char_sent       : one-cycle pulse when a frame completes
// Modports: master = message encoder / bench side, slave = serializer.
// ---------------------------------------------------------------------------
interface uart_tx_serializer_if #(
    parameter int DATA_BITS = 8
);
    logic                 load;
    logic [DATA_BITS-1:0] data_in;
    logic                 tx_out;
    logic                 busy;
    logic                 transmit_enable;
    logic [3:0]           bit_count;
    logic                 char_sent;

    modport master (
        output load,
        output data_in,
        input  tx_out,
        input  busy,
        input  transmit_enable,
        input  bit_count,
        input  char_sent
    );

    modport slave (
        input  load,
        input  data_in,
        output tx_out,
        output busy,
        output transmit_enable,
        output bit_count,
        output char_sent
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
// Transmit-side UART serializer: accepts a byte on a load strobe and shifts
// out an 8N1 frame (start, data LSB first, stop) at CLKS_PER_BIT clocks per
// bit. Optional even-parity bit between data and stop when the macro
// UART_TX_PARITY_EN is defined (frame becomes 11 bits).
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high, dominant
//   bus   : uart_tx_serializer_if.slave (load, data_in, tx_out, busy,
//           transmit_enable, bit_count, char_sent)
// All outputs come straight from flops; next-state values are computed in
// one combinational process and the outputs are derived from the next state
// so they line up with the state register.
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    uart_tx_serializer_if.slave    bus
);

    localparam int DIV_W = $clog2(CLKS_PER_BIT);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       LAST_BIT = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 te_q, te_d;
    logic                 char_sent_q, char_sent_d;
    logic                 boundary;

`ifdef UART_TX_PARITY_EN
    // Even parity of the captured byte, held for the PARITY bit.
    logic                 parity_q, parity_d;
`endif

    assign boundary = (div_q == DIV_LAST);

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        div_d       = div_q + 1'b1;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        char_sent_d = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d    = parity_q;
`endif
        case (state_q)
            IDLE: begin
                div_d = '0;
                if (bus.load) begin
                    state_d = START;
                    shift_d = bus.data_in;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^bus.data_in;
`endif
                end
            end
            START: begin
                if (boundary) begin
                    state_d = DATA;
                    div_d   = '0;
                end
            end
            DATA: begin
                if (boundary) begin
                    div_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (boundary) begin
                    state_d = STOP;
                    div_d   = '0;
                end
            end
`endif
            STOP: begin
                if (boundary) begin
                    state_d     = IDLE;
                    div_d       = '0;
                    char_sent_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                div_d   = '0;
            end
        endcase
    end

    // Output values for the cycle we are about to enter
    always_comb begin
        tx_d   = 1'b1;
        te_d   = 1'b0;
        busy_d = (state_d != IDLE);
        case (state_d)
            START: tx_d = 1'b0;
            DATA: begin
                // shift_d already holds the next bit at each boundary
                tx_d = shift_d[0];
                te_d = 1'b1;
            end
`ifdef UART_TX_PARITY_EN
            PARITY: tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            div_q       <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            te_q        <= 1'b0;
            char_sent_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            te_q        <= te_d;
            char_sent_q <= char_sent_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    assign bus.tx_out          = tx_q;
    assign bus.busy            = busy_q;
    assign bus.transmit_enable = te_q;
    assign bus.bit_count       = bit_cnt_q;
    assign bus.char_sent       = char_sent_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_serializer
// Directed bench for uart_tx_serializer at CLKS_PER_BIT=4. Expected frame
// contents are rebuilt from the transmitted byte by a small frame model.
// Build with UART_TX_PARITY_EN defined to exercise the parity frame.
// ---------------------------------------------------------------------------
module tb_uart_tx_serializer;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   cs_cyc = -1;

    uart_tx_serializer_if #(.DATA_BITS(8)) bus ();

    uart_tx_serializer #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        bus.load    = 1'b1;
        bus.data_in = d;
        tick();
        bus.load    = 1'b0;
    endtask

    // Checks every cycle from the one after the load edge up to and including
    // the char_sent cycle. inj_c injects a (should-be-ignored) load mid-frame;
    // chain loads chain_d in the char_sent cycle.
    task automatic check_frame(input logic [7:0] d, input int inj_c, input logic [7:0] inj_d,
                               input bit chain, input logic [7:0] chain_d);
        int   last;
        int   idx;
        int   bad;
        logic e_tx, e_busy, e_te, e_cs;
        logic [3:0] e_bc;
        logic [7:0] dv;
        dv   = d;
        last = NB * CPB + 1;
        bad  = errors;
        for (int c = 1; c <= last; c++) begin
            idx    = (c - 1) / CPB;
            e_busy = (c <= NB * CPB);
            e_te   = (idx >= 1) && (idx <= 8) && e_busy;
            e_bc   = e_te ? 4'(idx - 1) : 4'd0;
            e_cs   = (c == last);
            if (idx == 0)
                e_tx = 1'b0;
            else if (e_te)
                e_tx = dv[idx - 1];
            else if (NB == 11 && idx == 9)
                e_tx = ^dv;
            else
                e_tx = 1'b1;
            chk($sformatf("tx_out[%0h c%0d]", d, c), bus.tx_out, e_tx);
            chk($sformatf("busy[%0h c%0d]", d, c), bus.busy, e_busy);
            chk($sformatf("te[%0h c%0d]", d, c), bus.transmit_enable, e_te);
            chk($sformatf("bit_count[%0h c%0d]", d, c), bus.bit_count, e_bc);
            chk($sformatf("char_sent[%0h c%0d]", d, c), bus.char_sent, e_cs);
            if (c == last && bus.char_sent === 1'b1) cs_cyc = cyc;
            if (c == inj_c) begin
                bus.load    = 1'b1;
                bus.data_in = inj_d;
            end
            if (c == last && chain) begin
                bus.load    = 1'b1;
                bus.data_in = chain_d;
            end
            tick();
            bus.load = 1'b0;
        end
        $display("frame data=%02h char_sent_cycle=%0d frame_errors=%0d", d, cs_cyc, errors - bad);
    endtask

    initial begin
        int first_cs;
        bit seen_cs;

        // 1. Reset state
        reset       = 1'b1;
        bus.load    = 1'b0;
        bus.data_in = 8'h00;
        tick();
        tick();
        chk("reset tx_out", bus.tx_out, 1'b1);
        chk("reset busy", bus.busy, 1'b0);
        chk("reset bit_count", bus.bit_count, 4'd0);
        chk("reset char_sent", bus.char_sent, 1'b0);
        chk("reset te", bus.transmit_enable, 1'b0);
        reset = 1'b0;
        tick();
        $display("reset done");

        // 2+3. A5 frame, with an ignored load of 3C at cycle 10
        send(8'hA5);
        check_frame(8'hA5, 10, 8'h3C, 1'b0, 8'h00);
        tick();
        tick();

        // 4. 00 then FF loaded in the char_sent cycle
        send(8'h00);
        check_frame(8'h00, 0, 8'h00, 1'b1, 8'hFF);
        first_cs = cs_cyc;
        check_frame(8'hFF, 0, 8'h00, 1'b0, 8'h00);
        // One IDLE cycle separates the frames: the reload is taken at the
        // char_sent edge and the next frame has the normal load latency.
        chk("back-to-back char_sent gap", 32'(cs_cyc - first_cs), 32'(NB * CPB + 1));
        tick();

        // 5. Reset mid-frame at cycle 20
        send(8'hA5);
        for (int c = 1; c < 20; c++) tick();
        chk("pre-reset busy", bus.busy, 1'b1);
        reset = 1'b1;
        tick();
        chk("abort tx_out", bus.tx_out, 1'b1);
        chk("abort busy", bus.busy, 1'b0);
        chk("abort bit_count", bus.bit_count, 4'd0);
        chk("abort te", bus.transmit_enable, 1'b0);
        reset   = 1'b0;
        seen_cs = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (bus.char_sent === 1'b1) seen_cs = 1'b1;
            tick();
        end
        chk("no char_sent after abort", seen_cs, 1'b0);
        chk("idle tx after abort", bus.tx_out, 1'b1);
        $display("mid-frame reset done");

`ifdef UART_TX_PARITY_EN
        // 6. Parity frame: 07 has odd weight, parity bit 1, char_sent at 45
        send(8'h07);
        check_frame(8'h07, 0, 8'h00, 1'b0, 8'h00);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
